// File: rtl/tawas_pkg.sv
`default_nettype none
// ============================================================================
// Module   : tawas_pkg
// Brief    : Shared tawas core types and constants (PC width, slice count,
//            slice index and PC typedefs).
// Revision : 1.0 - initial release
// ============================================================================
package tawas_pkg;

  localparam int TAWAS_PC_W       = 24;
  localparam int TAWAS_NUM_SLICES = 4;

  typedef logic [1:0]            slice_t;
  typedef logic [TAWAS_PC_W-1:0] pc_t;

endpackage
`default_nettype wire

// File: rtl/tawas_rtn_stack_if.sv
`default_nettype none
// ============================================================================
// Module   : tawas_rtn_stack_if
// Brief    : Fetch <-> return-stack interface. Fetch is the master; the
//            return-address stack is the slave.
// Revision : 1.0 - initial release
// ============================================================================
interface tawas_rtn_stack_if
  import tawas_pkg::*;
#(
  parameter int PC_W = TAWAS_PC_W
);

  slice_t            slice;
  logic              pc_store;
  logic [PC_W-1:0]   pc_out;
  logic              pc_restore;
  logic [PC_W-1:0]   pc_rtn;

  modport master (
    output slice, pc_store, pc_out, pc_restore,
    input  pc_rtn
  );

  modport slave (
    input  slice, pc_store, pc_out, pc_restore,
    output pc_rtn
  );

endinterface
`default_nettype wire

// File: rtl/tawas_rtn_lifo.sv
`default_nettype none
// ============================================================================
// Module   : tawas_rtn_lifo
// Brief    : One circular return-address LIFO. Push overwrites the oldest
//            entry when full; push+pop replaces the top entry.
// Revision : 1.0 - initial release
// ============================================================================
module tawas_rtn_lifo
  import tawas_pkg::*;
#(
  parameter int DEPTH = 8,
  parameter int PC_W  = TAWAS_PC_W,
  parameter int CNT_W = $clog2(DEPTH) + 1
) (
  input  wire logic             clk,
  input  wire logic             rst,
  input  wire logic             push,
  input  wire logic             pop,
  input  wire logic [PC_W-1:0]  wdata,
  output logic      [PC_W-1:0]  top,
  output logic      [CNT_W-1:0] count,
  output logic                  ovf_pulse,
  output logic                  unf_pulse
);

  localparam int               PTR_W = $clog2(DEPTH);
  localparam logic [CNT_W-1:0] FULL  = CNT_W'(DEPTH);

  logic [PC_W-1:0]  mem [DEPTH];
  logic [PTR_W-1:0] ptr;
  logic [PTR_W-1:0] ptr_nxt;
  logic [CNT_W-1:0] cnt_nxt;
  logic [PTR_W-1:0] wr_addr;
  logic             wr_en;
  logic             empty;
  logic             full;

  assign empty     = (count == '0);
  assign full      = (count == FULL);
  assign top       = mem[ptr - 1'b1];
  assign ovf_pulse = push && !pop && full;
  assign unf_pulse = pop && empty;

  // Next-state decode: push (or push+pop on empty), replace-top, or pop.
  always_comb begin
    wr_en   = 1'b0;
    wr_addr = ptr;
    ptr_nxt = ptr;
    cnt_nxt = count;
    if (push && (!pop || empty)) begin
      wr_en   = 1'b1;
      wr_addr = ptr;
      ptr_nxt = ptr + 1'b1;
      cnt_nxt = full ? count : count + 1'b1;
    end else if (push && pop) begin
      wr_en   = 1'b1;
      wr_addr = ptr - 1'b1;
    end else if (pop && !empty) begin
      ptr_nxt = ptr - 1'b1;
      cnt_nxt = count - 1'b1;
    end
  end

  // Pointer and occupancy registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      ptr   <= '0;
      count <= '0;
    end else begin
      ptr   <= ptr_nxt;
      count <= cnt_nxt;
    end
  end

  // Entry storage is not reset; a write in a reset cycle is discarded.
  always_ff @(posedge clk) begin
    if (wr_en && !rst) begin
      mem[wr_addr] <= wdata;
    end
  end

endmodule
`default_nettype wire

// File: rtl/tawas_rtn_stack.sv
`default_nettype none
// ============================================================================
// Module   : tawas_rtn_stack
// Brief    : Per-slice hardware return-address stack (four LIFOs). Presents
//            the selected slice's top-of-stack combinationally on pc_rtn and
//            keeps sticky overflow/underflow flags per slice.
// Revision : 1.0 - initial release
// ============================================================================
module tawas_rtn_stack
  import tawas_pkg::*;
#(
  parameter int              DEPTH    = 8,
  parameter int              PC_W     = TAWAS_PC_W,
  parameter logic [PC_W-1:0] EMPTY_PC = '0
) (
  input  wire logic                                        clk,
  input  wire logic                                        rst,
  tawas_rtn_stack_if.slave                                 bus,
  output logic [TAWAS_NUM_SLICES*($clog2(DEPTH)+1)-1:0]    rtn_depth,
  output logic [TAWAS_NUM_SLICES-1:0]                      rtn_ovf,
  output logic [TAWAS_NUM_SLICES-1:0]                      rtn_unf,
  input  wire logic [TAWAS_NUM_SLICES-1:0]                 err_clr
);

  localparam int DW = $clog2(DEPTH) + 1;

  logic [PC_W-1:0]             top_arr [TAWAS_NUM_SLICES];
  logic [DW-1:0]               cnt_arr [TAWAS_NUM_SLICES];
  logic [TAWAS_NUM_SLICES-1:0] ovf_pulse;
  logic [TAWAS_NUM_SLICES-1:0] unf_pulse;

  for (genvar g = 0; g < TAWAS_NUM_SLICES; g++) begin : g_slice
    logic sel;
    assign sel = (bus.slice == slice_t'(g));

    tawas_rtn_lifo #(
      .DEPTH (DEPTH),
      .PC_W  (PC_W),
      .CNT_W (DW)
    ) u_lifo (
      .clk       (clk),
      .rst       (rst),
      .push      (bus.pc_store && sel),
      .pop       (bus.pc_restore && sel),
      .wdata     (bus.pc_out),
      .top       (top_arr[g]),
      .count     (cnt_arr[g]),
      .ovf_pulse (ovf_pulse[g]),
      .unf_pulse (unf_pulse[g])
    );

    assign rtn_depth[g*DW +: DW] = cnt_arr[g];
  end

  // Selected slice's top-of-stack, or EMPTY_PC when that stack is empty.
  always_comb begin
    bus.pc_rtn = top_arr[bus.slice];
    if (cnt_arr[bus.slice] == '0) begin
      bus.pc_rtn = EMPTY_PC;
    end
  end

  // Sticky error flags: a new event in the clearing cycle keeps the flag set.
  always_ff @(posedge clk) begin
    if (rst) begin
      rtn_ovf <= '0;
      rtn_unf <= '0;
    end else begin
      rtn_ovf <= (rtn_ovf & ~err_clr) | ovf_pulse;
      rtn_unf <= (rtn_unf & ~err_clr) | unf_pulse;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_tawas_rtn_stack.sv
`default_nettype none
// ============================================================================
// Module   : tb_tawas_rtn_stack
// Brief    : Directed self-checking bench for tawas_rtn_stack.
// Revision : 1.0 - initial release
// ============================================================================
module tb_tawas_rtn_stack;
  import tawas_pkg::*;

  localparam int              DEPTH    = 8;
  localparam int              PC_W     = 24;
  localparam logic [PC_W-1:0] EMPTY_PC = 24'h000000;
  localparam int              DW       = $clog2(DEPTH) + 1;

  logic                clk = 1'b0;
  logic                rst;
  logic [4*DW-1:0]     rtn_depth;
  logic [3:0]          rtn_ovf;
  logic [3:0]          rtn_unf;
  logic [3:0]          err_clr;

  int n_cmp = 0;
  int n_mis = 0;

  tawas_rtn_stack_if #(.PC_W(PC_W)) bus ();

  tawas_rtn_stack #(
    .DEPTH    (DEPTH),
    .PC_W     (PC_W),
    .EMPTY_PC (EMPTY_PC)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .bus       (bus),
    .rtn_depth (rtn_depth),
    .rtn_ovf   (rtn_ovf),
    .rtn_unf   (rtn_unf),
    .err_clr   (err_clr)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_mis++;
      $display("FAIL %s: got %h, expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] depth_of(input int s);
    return 32'(rtn_depth[s*DW +: DW]);
  endfunction

  task automatic idle();
    bus.pc_store   = 1'b0;
    bus.pc_restore = 1'b0;
    err_clr        = 4'b0;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input int s, input logic [PC_W-1:0] pc);
    bus.slice = slice_t'(s); bus.pc_store = 1'b1; bus.pc_out = pc;
    tick();
    idle();
  endtask

  // Pop slice s, checking pc_rtn in the pop cycle.
  task automatic pop_chk(input int s, input logic [PC_W-1:0] exp, input string tag);
    bus.slice = slice_t'(s); bus.pc_restore = 1'b1;
    #1;
    check(tag, 32'(bus.pc_rtn), 32'(exp));
    tick();
    idle();
  endtask

  task automatic peek(input int s, input logic [PC_W-1:0] exp, input string tag);
    bus.slice = slice_t'(s);
    #1;
    check(tag, 32'(bus.pc_rtn), 32'(exp));
  endtask

  initial begin
    bus.slice = '0; bus.pc_out = '0;
    idle();
    rst = 1'b1;
    tick(); tick();
    rst = 1'b0;

    // Reset state
    check("rst_depth", 32'(rtn_depth), 32'h0);
    check("rst_ovf",   32'(rtn_ovf),   32'h0);
    check("rst_unf",   32'(rtn_unf),   32'h0);
    peek(0, EMPTY_PC, "rst_pc_rtn");

    // Basic call/return on slice 1
    push(1, 24'h000100);
    push(1, 24'h000200);
    peek(1, 24'h000200, "basic_top2");
    pop_chk(1, 24'h000200, "basic_pop1");
    peek(1, 24'h000100, "basic_top1");
    pop_chk(1, 24'h000100, "basic_pop2");
    peek(1, EMPTY_PC, "basic_empty");
    check("basic_depth1", depth_of(1), 32'd0);
    check("basic_flags", {28'b0, rtn_ovf | rtn_unf}, 32'h0);

    // Slice isolation
    for (int s = 0; s < 4; s++) push(s, 24'h0000A0 + 24'(s));
    check("iso_depth_all", 32'(rtn_depth), 32'h1111);
    pop_chk(0, 24'h0000A0, "iso_pop0");
    check("iso_depth_a", 32'(rtn_depth), 32'h1110);
    pop_chk(1, 24'h0000A1, "iso_pop1");
    check("iso_depth_b", 32'(rtn_depth), 32'h1100);
    pop_chk(2, 24'h0000A2, "iso_pop2");
    check("iso_depth_c", 32'(rtn_depth), 32'h1000);
    pop_chk(3, 24'h0000A3, "iso_pop3");
    check("iso_depth_d", 32'(rtn_depth), 32'h0000);

    // Overflow on slice 2
    for (int i = 0; i < 9; i++) push(2, 24'h000010 + 24'(i));
    check("ovf_flag",  32'(rtn_ovf), 32'h4);
    check("ovf_depth", depth_of(2), 32'd8);
    for (int i = 0; i < 8; i++) pop_chk(2, 24'h000018 - 24'(i), $sformatf("ovf_pop%0d", i));
    peek(2, EMPTY_PC, "ovf_empty");
    check("ovf_unf_before", 32'(rtn_unf), 32'h0);
    pop_chk(2, EMPTY_PC, "ovf_pop9");
    check("ovf_unf_after", 32'(rtn_unf), 32'h4);
    err_clr = 4'b0100;
    tick();
    idle();
    check("ovf_clr", {28'b0, rtn_ovf | rtn_unf}, 32'h0);

    // Underflow and clear on slice 3
    pop_chk(3, EMPTY_PC, "unf_pop");
    check("unf_flag", 32'(rtn_unf), 32'h8);
    err_clr = 4'b1000;
    tick();
    idle();
    check("unf_clr", 32'(rtn_unf), 32'h0);
    bus.slice = 2'd3; bus.pc_restore = 1'b1; err_clr = 4'b1000;
    tick();
    idle();
    check("unf_set_wins", 32'(rtn_unf), 32'h8);
    check("unf_depth3", depth_of(3), 32'd0);
    err_clr = 4'b1000;
    tick();
    idle();

    // Replace-top on slice 0
    push(0, 24'h000055);
    bus.slice = 2'd0; bus.pc_store = 1'b1; bus.pc_restore = 1'b1; bus.pc_out = 24'h000077;
    #1;
    check("rpl_same_cycle", 32'(bus.pc_rtn), 32'h000055);
    tick();
    idle();
    peek(0, 24'h000077, "rpl_next");
    check("rpl_depth", depth_of(0), 32'd1);
    check("rpl_flags", {28'b0, rtn_ovf | rtn_unf}, 32'h0);
    pop_chk(0, 24'h000077, "rpl_pop");

    // Reset mid-operation
    push(1, 24'h000001);
    push(1, 24'h000002);
    push(1, 24'h000003);
    pop_chk(3, EMPTY_PC, "mid_unf_pop");
    check("mid_pre_depth1", depth_of(1), 32'd3);
    bus.slice = 2'd1; bus.pc_store = 1'b1; bus.pc_out = 24'h000004; rst = 1'b1;
    tick();
    idle();
    rst = 1'b0;
    check("mid_depth", 32'(rtn_depth), 32'h0);
    check("mid_flags", {28'b0, rtn_ovf | rtn_unf}, 32'h0);
    peek(1, EMPTY_PC, "mid_pc_rtn");
    tick();
    check("mid_depth_after", depth_of(1), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule
`default_nettype wire
